// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the PC, issues one word fetch at a time and hands each
// returned word to decode over a valid/ready handshake. Redirects discard any fetch in flight.
//
// state | meaning
// IDLE  | one cycle after reset release, no request yet
// REQ   | request presented at pc, waiting for memory to accept
// WAIT  | request accepted, waiting for the single response
// HOLD  | instruction registered and offered to decode
// HALT  | access fault seen, stage stopped until reset
module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    input  logic                  mem_rsp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  fetch_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic                    drop_q;
    logic [DATA_WIDTH-1:0]   inst_q;
    logic [ADDR_WIDTH-1:0]   inst_pc_q;
    logic                    fetch_err_q;

    logic [ADDR_WIDTH-1:0]   redirect_pc_aligned;

    assign redirect_pc_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: state_q <= REQ;

                REQ: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc_aligned;
                        // Accepted request still fetches the old pc; its response must be dropped.
                        if (mem_req_ready) begin
                            drop_q  <= 1'b1;
                            state_q <= WAIT;
                        end
                    end else if (mem_req_ready) begin
                        state_q <= WAIT;
                    end
                end

                WAIT: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc_aligned;
                        if (mem_rsp_valid) begin
                            drop_q  <= 1'b0;
                            state_q <= REQ;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end else if (mem_rsp_valid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= REQ;
                        end else if (mem_rsp_err) begin
                            fetch_err_q <= 1'b1;
                            state_q     <= HALT;
                        end else begin
                            inst_q    <= mem_rsp_data;
                            inst_pc_q <= pc_q;
                            state_q   <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc_aligned;
                        state_q <= REQ;
                    end else if (inst_ready) begin
                        pc_q    <= pc_q + ADDR_WIDTH'(4);
                        state_q <= REQ;
                    end
                end

                HALT: state_q <= HALT;

                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = pc_q;
    assign inst_valid    = (state_q == HOLD);
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign fetch_err     = fetch_err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a small responder returns one word per accepted request
// after a programmable delay; the main sequence steps cycle by cycle with hand-computed values.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    logic [31:0] rsp_word;
    logic        rsp_err;
    int          rsp_lat;

    int n_checks;
    int n_errors;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_err    (mem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model: one response per accepted request, rsp_lat extra cycles after the minimum.
    initial begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req_valid && mem_req_ready) begin
                @(posedge clk);
                repeat (rsp_lat) @(posedge clk);
                #1;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = rsp_word;
                mem_rsp_err   = rsp_err;
                @(posedge clk);
                #1;
                mem_rsp_valid = 1'b0;
                mem_rsp_err   = 1'b0;
                mem_rsp_data  = '0;
            end
        end
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        mem_req_ready  = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rsp_word       = 32'h0000_0013;
        rsp_err        = 1'b0;
        rsp_lat        = 0;
        repeat (3) step();

        check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        check("rst_addr", mem_req_addr, 32'h8000_0000);

        // 1: first fetch after reset release
        mem_req_ready = 1'b1;
        rst = 1'b0;
        step();
        check("t1_req_valid", {31'd0, mem_req_valid}, 32'd1);
        check("t1_req_addr", mem_req_addr, 32'h8000_0000);
        step();
        check("t1_wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("t1_wait_inst_valid", {31'd0, inst_valid}, 32'd0);
        step();
        check("t1_inst_valid", {31'd0, inst_valid}, 32'd1);
        check("t1_inst", inst, 32'h0000_0013);
        check("t1_inst_pc", inst_pc, 32'h8000_0000);

        // 2: decode back-pressure holds the instruction and blocks further fetch
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_hold_valid", {31'd0, inst_valid}, 32'd1);
            check("t2_hold_inst", inst, 32'h0000_0013);
            check("t2_hold_pc", inst_pc, 32'h8000_0000);
            check("t2_no_req", {31'd0, mem_req_valid}, 32'd0);
        end
        inst_ready = 1'b1;
        mem_req_ready = 1'b0;
        step();
        inst_ready = 1'b0;
        check("t2_consumed", {31'd0, inst_valid}, 32'd0);
        check("t2_next_req", {31'd0, mem_req_valid}, 32'd1);
        check("t2_next_addr", mem_req_addr, 32'h8000_0004);

        // 3: memory stalls the request
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_stall_valid", {31'd0, mem_req_valid}, 32'd1);
            check("t3_stall_addr", mem_req_addr, 32'h8000_0004);
        end
        rsp_word = 32'h0010_0093;
        mem_req_ready = 1'b1;
        step();
        check("t3_wait", {31'd0, mem_req_valid}, 32'd0);
        step();
        check("t3_inst", inst, 32'h0010_0093);
        check("t3_inst_pc", inst_pc, 32'h8000_0004);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("t3_next_addr", mem_req_addr, 32'h8000_0008);

        // 4: redirect during WAIT, late response discarded
        rsp_word = 32'hDEAD_BEEF;
        rsp_lat  = 3;
        step();
        check("t4_wait", {31'd0, mem_req_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        step();
        redirect_valid = 1'b0;
        check("t4_still_wait", {31'd0, mem_req_valid}, 32'd0);
        step();
        step();
        check("t4_rsp_present", {31'd0, mem_rsp_valid}, 32'd1);
        rsp_lat = 0;
        step();
        check("t4_no_inst", {31'd0, inst_valid}, 32'd0);
        check("t4_refetch", {31'd0, mem_req_valid}, 32'd1);
        check("t4_refetch_addr", mem_req_addr, 32'h8000_0100);
        rsp_word = 32'h0020_0113;
        step();
        step();
        check("t4_inst", inst, 32'h0020_0113);
        check("t4_inst_pc", inst_pc, 32'h8000_0100);

        // 5: redirect wins over a same-cycle consume
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        check("t5_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("t5_req_addr", mem_req_addr, 32'h8000_0200);
        rsp_word = 32'h0030_0193;
        step();
        step();
        check("t5_inst_pc", inst_pc, 32'h8000_0200);
        check("t5_inst", inst, 32'h0030_0193);

        // PC alignment and wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        check("wrap_aligned", mem_req_addr, 32'hFFFF_FFFC);
        step();
        step();
        check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);

        // 6: access fault halts the stage until reset
        rsp_err    = 1'b1;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("wrap_addr", mem_req_addr, 32'h0000_0000);
        step();
        step();
        rsp_err = 1'b0;
        check("t6_fetch_err", {31'd0, fetch_err}, 32'd1);
        check("t6_inst_valid", {31'd0, inst_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_halt_no_req", {31'd0, mem_req_valid}, 32'd0);
            check("t6_err_sticky", {31'd0, fetch_err}, 32'd1);
        end
        rst = 1'b1;
        step();
        check("t6_rst_err", {31'd0, fetch_err}, 32'd0);
        check("t6_rst_addr", mem_req_addr, 32'h8000_0000);
        rst = 1'b0;
        step();
        check("t6_refetch", {31'd0, mem_req_valid}, 32'd1);
        check("t6_refetch_addr", mem_req_addr, 32'h8000_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
